// File: rtl/ctrl_pkg.sv
// Shared control-bundle types and opcode constants for the RV32 decode stage.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } immSrc_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } resultSrc_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_PASSB = 2'b11
  } aluOp_e;

  typedef struct packed {
    logic       regWrite;
    immSrc_e    immSrc;
    logic       aluSrc;
    logic       aluAPc;
    logic       memWrite;
    resultSrc_e resultSrc;
    logic       branch;
    logic       jump;
    aluOp_e     aluOp;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decode_stage_opcode_decoder.sv
// Combinational opcode-to-control table; extension opcodes gated by EXT_EN.
module opcode_decoder
  import ctrl_pkg::*;
#(
  parameter bit EXT_EN = 1'b1
) (
  input  logic [6:0] op,
  output ctrl_t      ctrl,
  output logic       illegal
);

  // Opcode table lookup; anything unrecognised becomes a flagged NOP.
  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    case (op)
      OP_LOAD: begin
        ctrl.regWrite = 1'b1; ctrl.aluSrc = 1'b1; ctrl.resultSrc = RES_MEM;
      end
      OP_STORE: begin
        ctrl.memWrite = 1'b1; ctrl.aluSrc = 1'b1; ctrl.immSrc = IMM_S;
      end
      OP_RTYPE: begin
        ctrl.regWrite = 1'b1; ctrl.aluOp = ALU_FUNCT;
      end
      OP_IALU: begin
        ctrl.regWrite = 1'b1; ctrl.aluSrc = 1'b1; ctrl.aluOp = ALU_FUNCT;
      end
      OP_BRANCH: begin
        ctrl.branch = 1'b1; ctrl.immSrc = IMM_B; ctrl.aluOp = ALU_SUB;
      end
      OP_JAL: begin
        if (EXT_EN) begin
          ctrl.regWrite = 1'b1; ctrl.jump = 1'b1; ctrl.immSrc = IMM_J; ctrl.resultSrc = RES_PC4;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_JALR: begin
        if (EXT_EN) begin
          ctrl.regWrite = 1'b1; ctrl.jump = 1'b1; ctrl.aluSrc = 1'b1; ctrl.resultSrc = RES_PC4;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_LUI: begin
        if (EXT_EN) begin
          ctrl.regWrite = 1'b1; ctrl.aluSrc = 1'b1; ctrl.immSrc = IMM_U; ctrl.aluOp = ALU_PASSB;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_AUIPC: begin
        if (EXT_EN) begin
          ctrl.regWrite = 1'b1; ctrl.aluSrc = 1'b1; ctrl.aluAPc = 1'b1; ctrl.immSrc = IMM_U;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered main-control decode stage: decoder plus a 1-entry valid/ready
// pipeline register with flush and a saturating illegal-opcode counter.
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter bit EXT_EN    = 1'b1,
  parameter int TAG_W     = 32,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           in_op,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_reg_write,
  output logic [2:0]           out_imm_src,
  output logic                 out_alu_src,
  output logic                 out_alu_a_pc,
  output logic                 out_mem_write,
  output logic [1:0]           out_result_src,
  output logic                 out_branch,
  output logic                 out_jump,
  output logic [1:0]           out_alu_op,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  ctrl_t                decCtrlS;
  logic                 decIllegalS;
  logic                 acceptS;
  ctrl_t                ctrlR;
  logic                 validR;
  logic                 illegalR;
  logic [TAG_W-1:0]     tagR;
  logic [ILL_CNT_W-1:0] illCntR;

  opcode_decoder #(.EXT_EN(EXT_EN)) uDecoder (
    .op      (in_op),
    .ctrl    (decCtrlS),
    .illegal (decIllegalS)
  );

  assign in_ready = !validR || out_ready;
  assign acceptS  = in_valid && in_ready && !flush;

  // Pipeline register; flush wins over any handshake and clears the controls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      validR   <= 1'b0;
      ctrlR    <= CTRL_NOP;
      illegalR <= 1'b0;
      tagR     <= '0;
      illCntR  <= '0;
    end else if (flush) begin
      validR   <= 1'b0;
      ctrlR    <= CTRL_NOP;
      illegalR <= 1'b0;
    end else if (acceptS) begin
      validR   <= 1'b1;
      ctrlR    <= decCtrlS;
      illegalR <= decIllegalS;
      tagR     <= in_tag;
      if (decIllegalS && (illCntR != {ILL_CNT_W{1'b1}})) begin
        illCntR <= illCntR + ILL_CNT_W'(1);
      end else begin
        illCntR <= illCntR;
      end
    end else if (validR && out_ready) begin
      validR <= 1'b0;
    end else begin
      validR <= validR;
    end
  end

  assign out_valid      = validR;
  assign out_reg_write  = ctrlR.regWrite;
  assign out_imm_src    = ctrlR.immSrc;
  assign out_alu_src    = ctrlR.aluSrc;
  assign out_alu_a_pc   = ctrlR.aluAPc;
  assign out_mem_write  = ctrlR.memWrite;
  assign out_result_src = ctrlR.resultSrc;
  assign out_branch     = ctrlR.branch;
  assign out_jump       = ctrlR.jump;
  assign out_alu_op     = ctrlR.aluOp;
  assign out_tag        = tagR;
  assign out_illegal    = illegalR;
  assign ill_count      = illCntR;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Self-checking bench: two stage instances (EXT_EN=1/W=8 and EXT_EN=0/W=2)
// checked every cycle against a table-driven reference plus literal spot checks.
module tb_ctrl_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstI[2], flushI[2], inValid[2], outReady[2];
  logic [6:0]  inOp[2];
  logic [31:0] inTag[2];

  logic        inReadyO[2], outValidO[2], regW[2], aluSrc[2], aPc[2], memW[2];
  logic        br[2], jmp[2], illO[2];
  logic [2:0]  imm[2];
  logic [1:0]  res[2], aop[2];
  logic [31:0] tagO[2];
  logic [7:0]  cnt0;
  logic [1:0]  cnt1;

  int total = 0;
  int bad   = 0;

  ctrl_decode_stage #(.EXT_EN(1'b1), .TAG_W(32), .ILL_CNT_W(8)) dutA (
    .clk(clk), .rst(rstI[0]), .flush(flushI[0]), .in_valid(inValid[0]), .in_ready(inReadyO[0]),
    .in_op(inOp[0]), .in_tag(inTag[0]), .out_valid(outValidO[0]), .out_ready(outReady[0]),
    .out_reg_write(regW[0]), .out_imm_src(imm[0]), .out_alu_src(aluSrc[0]), .out_alu_a_pc(aPc[0]),
    .out_mem_write(memW[0]), .out_result_src(res[0]), .out_branch(br[0]), .out_jump(jmp[0]),
    .out_alu_op(aop[0]), .out_tag(tagO[0]), .out_illegal(illO[0]), .ill_count(cnt0)
  );

  ctrl_decode_stage #(.EXT_EN(1'b0), .TAG_W(32), .ILL_CNT_W(2)) dutB (
    .clk(clk), .rst(rstI[1]), .flush(flushI[1]), .in_valid(inValid[1]), .in_ready(inReadyO[1]),
    .in_op(inOp[1]), .in_tag(inTag[1]), .out_valid(outValidO[1]), .out_ready(outReady[1]),
    .out_reg_write(regW[1]), .out_imm_src(imm[1]), .out_alu_src(aluSrc[1]), .out_alu_a_pc(aPc[1]),
    .out_mem_write(memW[1]), .out_result_src(res[1]), .out_branch(br[1]), .out_jump(jmp[1]),
    .out_alu_op(aop[1]), .out_tag(tagO[1]), .out_illegal(illO[1]), .ill_count(cnt1)
  );

  // Reference table: bundle = {rw, imm[2:0], aluSrc, aPc, memW, res[1:0], br, jmp, aluOp[1:0]}
  typedef struct {
    logic [6:0]  op;
    bit          ext;
    logic [12:0] c;
  } entry_t;
  entry_t tab[9];

  bit          mValid[2];
  logic [12:0] mCtrl[2];
  logic [31:0] mTag[2];
  bit          mIll[2];
  int          mCnt[2];
  bit          mExt[2];
  int          mMax[2];

  function automatic logic [12:0] mk(bit rw, logic [2:0] im, bit as, bit pc, bit mw,
                                     logic [1:0] rs, bit b, bit j, logic [1:0] ao);
    return {rw, im, as, pc, mw, rs, b, j, ao};
  endfunction

  function automatic bit refIll(logic [6:0] op, bit ext);
    for (int i = 0; i < 9; i++)
      if (tab[i].op == op && (!tab[i].ext || ext)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [12:0] refCtrl(logic [6:0] op, bit ext);
    for (int i = 0; i < 9; i++)
      if (tab[i].op == op && (!tab[i].ext || ext)) return tab[i].c;
    return 13'd0;
  endfunction

  function automatic logic [12:0] dutCtrl(int k);
    return {regW[k], imm[k], aluSrc[k], aPc[k], memW[k], res[k], br[k], jmp[k], aop[k]};
  endfunction

  function automatic int dutCnt(int k);
    return (k == 0) ? int'(cnt0) : int'(cnt1);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: advances one transfer per clock from the sampled inputs.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rstI[k]) begin
        mValid[k] <= 1'b0; mCtrl[k] <= 13'd0; mIll[k] <= 1'b0; mTag[k] <= 32'd0; mCnt[k] <= 0;
      end else if (flushI[k]) begin
        mValid[k] <= 1'b0; mCtrl[k] <= 13'd0; mIll[k] <= 1'b0;
      end else if (inValid[k] && (!mValid[k] || outReady[k])) begin
        mValid[k] <= 1'b1;
        mCtrl[k]  <= refCtrl(inOp[k], mExt[k]);
        mIll[k]   <= refIll(inOp[k], mExt[k]);
        mTag[k]   <= inTag[k];
        if (refIll(inOp[k], mExt[k]) && mCnt[k] < mMax[k]) mCnt[k] <= mCnt[k] + 1;
      end else if (outReady[k]) begin
        mValid[k] <= 1'b0;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("valid%0d", k), 32'(outValidO[k]), 32'(mValid[k]));
      chk($sformatf("ready%0d", k), 32'(inReadyO[k]), 32'(!mValid[k] || outReady[k]));
      chk($sformatf("ctrl%0d", k), 32'(dutCtrl(k)), 32'(mCtrl[k]));
      chk($sformatf("tag%0d", k), tagO[k], mTag[k]);
      chk($sformatf("illegal%0d", k), 32'(illO[k]), 32'(mIll[k]));
      chk($sformatf("count%0d", k), 32'(dutCnt(k)), 32'(mCnt[k]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] allOps[9];
  logic [6:0] illOps[4];
  int         cntExp[4];

  initial begin
    tab[0] = '{7'b0000011, 1'b0, mk(1, 3'b000, 1, 0, 0, 2'b01, 0, 0, 2'b00)};
    tab[1] = '{7'b0100011, 1'b0, mk(0, 3'b001, 1, 0, 1, 2'b00, 0, 0, 2'b00)};
    tab[2] = '{7'b0110011, 1'b0, mk(1, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b10)};
    tab[3] = '{7'b0010011, 1'b0, mk(1, 3'b000, 1, 0, 0, 2'b00, 0, 0, 2'b10)};
    tab[4] = '{7'b1100011, 1'b0, mk(0, 3'b010, 0, 0, 0, 2'b00, 1, 0, 2'b01)};
    tab[5] = '{7'b1101111, 1'b1, mk(1, 3'b011, 0, 0, 0, 2'b10, 0, 1, 2'b00)};
    tab[6] = '{7'b1100111, 1'b1, mk(1, 3'b000, 1, 0, 0, 2'b10, 0, 1, 2'b00)};
    tab[7] = '{7'b0110111, 1'b1, mk(1, 3'b100, 1, 0, 0, 2'b00, 0, 0, 2'b11)};
    tab[8] = '{7'b0010111, 1'b1, mk(1, 3'b100, 1, 1, 0, 2'b00, 0, 0, 2'b00)};
    for (int i = 0; i < 9; i++) allOps[i] = tab[i].op;
    illOps = '{7'h7F, 7'b1100111, 7'b0110111, 7'h00};
    cntExp = '{2, 3, 3, 3};
    mExt = '{1'b1, 1'b0};
    mMax = '{255, 3};
    mValid = '{1'b0, 1'b0}; mCtrl = '{13'd0, 13'd0}; mTag = '{32'd0, 32'd0};
    mIll = '{1'b0, 1'b0}; mCnt = '{0, 0};
    for (int k = 0; k < 2; k++) begin
      rstI[k] = 1'b0; flushI[k] = 1'b0; inValid[k] = 1'b0; outReady[k] = 1'b1;
      inOp[k] = 7'd0; inTag[k] = 32'd0;
    end

    // Reset state
    tick(); tick();
    chk("rst_valid", 32'(outValidO[0]), 32'd0);
    chk("rst_ready", 32'(inReadyO[0]), 32'd1);
    chk("rst_count", 32'(cnt0), 32'd0);
    rstI[0] = 1'b1; rstI[1] = 1'b1;
    tick();

    // R-type after reset
    inValid[0] = 1'b1; inOp[0] = 7'b0110011; inTag[0] = 32'd100;
    tick();
    chk("r_valid", 32'(outValidO[0]), 32'd1);
    chk("r_regw", 32'(regW[0]), 32'd1);
    chk("r_aluop", 32'(aop[0]), 32'd2);

    // All nine opcodes back-to-back
    for (int i = 0; i < 9; i++) begin
      inOp[0] = allOps[i]; inTag[0] = 32'd200 + 32'(i);
      tick();
      chk("seq_tag", tagO[0], 32'd200 + 32'(i));
    end
    chk("auipc_apc", 32'(aPc[0]), 32'd1);
    inValid[0] = 1'b0;
    tick();
    chk("drain_valid", 32'(outValidO[0]), 32'd0);

    // Stall with held LW while an illegal opcode is offered
    inValid[0] = 1'b1; inOp[0] = 7'b0000011; inTag[0] = 32'd300; outReady[0] = 1'b0;
    tick();
    inOp[0] = 7'h7F; inTag[0] = 32'd999;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ready", 32'(inReadyO[0]), 32'd0);
      chk("stall_tag", tagO[0], 32'd300);
      chk("stall_res", 32'(res[0]), 32'd1);
    end
    chk("stall_count", 32'(cnt0), 32'd0);
    inOp[0] = 7'b0100011; inTag[0] = 32'd301; outReady[0] = 1'b1;
    tick();
    chk("release_tag", tagO[0], 32'd301);
    chk("release_memw", 32'(memW[0]), 32'd1);
    inValid[0] = 1'b0;
    tick();
    chk("hold_memw", 32'(memW[0]), 32'd1);

    // Flush blocks a same-cycle accept, then kills a held entry
    flushI[0] = 1'b1; inValid[0] = 1'b1; inOp[0] = 7'b0100011; inTag[0] = 32'd400;
    tick();
    chk("flush_valid", 32'(outValidO[0]), 32'd0);
    chk("flush_memw", 32'(memW[0]), 32'd0);
    chk("flush_count", 32'(cnt0), 32'd0);
    flushI[0] = 1'b0; inOp[0] = 7'b0000011; inTag[0] = 32'd500; outReady[0] = 1'b0;
    tick();
    flushI[0] = 1'b1; inValid[0] = 1'b0;
    tick();
    chk("flush_held", 32'(outValidO[0]), 32'd0);
    chk("flush_regw", 32'(regW[0]), 32'd0);
    flushI[0] = 1'b0; outReady[0] = 1'b1;
    tick();

    // EXT_EN=0 instance: JAL illegal, then saturation at 2 bits
    inValid[1] = 1'b1; inOp[1] = 7'b1101111; inTag[1] = 32'd600;
    tick();
    chk("jal_ill", 32'(illO[1]), 32'd1);
    chk("jal_ctrl", 32'(dutCtrl(1)), 32'd0);
    chk("jal_count", 32'(cnt1), 32'd1);
    inOp[1] = 7'b0000011; inTag[1] = 32'd601;
    tick();
    chk("lw_ill", 32'(illO[1]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      inOp[1] = illOps[i];
      tick();
      chk("sat_count", 32'(cnt1), 32'(cntExp[i]));
    end
    flushI[1] = 1'b1; inOp[1] = 7'h7F;
    tick();
    chk("flushed_ill", 32'(illO[1]), 32'd0);
    flushI[1] = 1'b0; inOp[1] = 7'b0010111; outReady[1] = 1'b0;
    tick();
    chk("b_held", 32'(outValidO[1]), 32'd1);
    rstI[1] = 1'b0; inValid[1] = 1'b0;
    tick();
    chk("midrst_valid", 32'(outValidO[1]), 32'd0);
    chk("midrst_count", 32'(cnt1), 32'd0);
    rstI[1] = 1'b1; outReady[1] = 1'b1;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
